// File: rtl/fw_motor_pkg.sv
// Shared types and constants for the filter-wheel stepper sequencer.
package fw_motor_pkg;

    localparam int DEAD_CYCLES_DEFAULT = 8;
    localparam int MIN_PERIOD_DEFAULT  = 64;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_DEAD  = 2'd1,
        SEQ_DWELL = 2'd2
    } seqState_t;

    typedef enum logic [1:0] {
        COIL_OFF = 2'd0,
        COIL_FWD = 2'd1,
        COIL_REV = 2'd2
    } coilCode_t;

    typedef struct packed {
        coilCode_t a;
        coilCode_t b;
    } coilPair_t;

    // Electrical phase -> (A,B) coil polarity; index 0 is the leftmost entry.
    localparam coilPair_t [0:3] PHASE_TABLE = {
        {COIL_FWD, COIL_FWD},
        {COIL_REV, COIL_FWD},
        {COIL_REV, COIL_REV},
        {COIL_FWD, COIL_REV}
    };

    function automatic coilPair_t phaseCoils(input logic [1:0] ph);
        return PHASE_TABLE[ph];
    endfunction

    // Forward steps from even phases and reverse steps from odd phases move coil A.
    function automatic logic changesCoilA(input logic [1:0] ph, input logic fwd);
        return ph[0] ^ fwd;
    endfunction

endpackage

// File: rtl/fw_coil_driver.sv
// Maps one coil code onto its H-bridge gate signals (high-side Plus/Minus, low-side Prime).
module fw_coil_driver
    import fw_motor_pkg::*;
(
    input  coilCode_t code,
    output logic      plus,
    output logic      minus,
    output logic      plusPrime,
    output logic      minusPrime
);

    always_comb begin
        plus       = (code == COIL_FWD);
        minusPrime = (code == COIL_FWD);
        minus      = (code == COIL_REV);
        plusPrime  = (code == COIL_REV);
    end

endmodule

// File: rtl/fw_stepper_sequencer.sv
// Full-step two-phase-on stepper sequencer with dead time and step pacing.
// Optional home-sensor stop is compiled in with FW_HOME_STOP_EN.
module fw_stepper_sequencer
    import fw_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int MIN_PERIOD  = MIN_PERIOD_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             DEVRST_N,
    // A command transfers on a clk edge where cmd_valid and cmd_ready are both high;
    // cmd_ready is high only in IDLE and the command fields are sampled at that edge.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0] step_period,
    input  logic             hold_en,
    input  logic             abort,
    input  logic             home_raw,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             home_hit,
    output logic [CNT_W-1:0] steps_left,
    output logic [1:0]       phase,
    output logic             MotorDriveAPlus,
    output logic             MotorDriveAMinus,
    output logic             MotorDriveBPlus,
    output logic             MotorDriveBMinus,
    output logic             MotorDriveAPlusPrime,
    output logic             MotorDriveAMinusPrime,
    output logic             MotorDriveBPlusPrime,
    output logic             MotorDriveBMinusPrime,
    output logic [1:0]       dbgState
);

    localparam logic [1:0] S_IDLE  = SEQ_IDLE;
    localparam logic [1:0] S_DEAD  = SEQ_DEAD;
    localparam logic [1:0] S_DWELL = SEQ_DWELL;

    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(MIN_PERIOD);

    logic [1:0]       state, stateN;
    logic [1:0]       phaseN;
    logic             dir, dirN;
    logic             prime, primeN;
    logic [CNT_W-1:0] period, periodN;
    logic [CNT_W-1:0] cnt, cntN;
    logic [CNT_W-1:0] stepsN;
    logic             doneN, abortedN, homeHitN;
    logic             homeRise;
    coilPair_t        pairN;
    coilCode_t        aCodeN, bCodeN;
    logic [3:0]       aGatesN, bGatesN;

    assign dbgState = state;

`ifdef FW_HOME_STOP_EN
    logic [1:0] homeSync;
    logic       homePrev;

    always_ff @(posedge clk or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            homeSync <= 2'b00;
            homePrev <= 1'b0;
        end else begin
            homeSync <= {homeSync[0], home_raw};
            homePrev <= homeSync[1];
        end
    end

    assign homeRise = homeSync[1] & ~homePrev;
`else
    logic unusedHomeRaw;
    assign unusedHomeRaw = home_raw;
    assign homeRise      = 1'b0;
`endif

    always_comb begin
        stateN   = state;
        phaseN   = phase;
        dirN     = dir;
        primeN   = prime;
        periodN  = period;
        cntN     = cnt;
        stepsN   = steps_left;
        doneN    = 1'b0;
        abortedN = aborted;
        homeHitN = home_hit;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dirN     = cmd_dir;
                    stepsN   = cmd_steps;
                    periodN  = (step_period < PERIOD_MIN) ? PERIOD_MIN : step_period;
                    abortedN = 1'b0;
                    homeHitN = 1'b0;
                    if (cmd_steps == '0) begin
                        doneN = 1'b1;
                    end else begin
                        stateN = S_DEAD;
                        cntN   = DEAD_LOAD;
                        // An unheld start energizes both coils first so motion never begins on one coil.
                        primeN = ~hold_en;
                    end
                end
            end
            S_DEAD: begin
                if (cnt == '0) begin
                    if (prime) begin
                        primeN = 1'b0;
                        cntN   = DEAD_LOAD;
                    end else begin
                        phaseN = dir ? phase + 2'd1 : phase - 2'd1;
                        stateN = S_DWELL;
                        cntN   = period - 1'b1;
                    end
                end else begin
                    cntN = cnt - 1'b1;
                end
            end
            S_DWELL: begin
                if (cnt == '0) begin
                    stepsN = steps_left - 1'b1;
                    if (steps_left == CNT_W'(1)) begin
                        stateN = S_IDLE;
                        doneN  = 1'b1;
                    end else begin
                        stateN = S_DEAD;
                        cntN   = DEAD_LOAD;
                    end
                end else begin
                    cntN = cnt - 1'b1;
                end
            end
            default: stateN = S_IDLE;
        endcase
        // Early termination keeps the last fully applied phase and the residual step count.
        if (state != S_IDLE && (abort || homeRise)) begin
            stateN   = S_IDLE;
            phaseN   = phase;
            stepsN   = steps_left;
            primeN   = 1'b0;
            doneN    = 1'b1;
            abortedN = abort;
            homeHitN = ~abort;
        end
    end

    always_comb begin
        pairN  = phaseCoils(phaseN);
        aCodeN = pairN.a;
        bCodeN = pairN.b;
        if (stateN == S_IDLE && !hold_en) begin
            aCodeN = COIL_OFF;
            bCodeN = COIL_OFF;
        end else if (stateN == S_DEAD && !primeN) begin
            if (changesCoilA(phaseN, dirN)) aCodeN = COIL_OFF;
            else                            bCodeN = COIL_OFF;
        end
    end

    fw_coil_driver uCoilA (
        .code       (aCodeN),
        .plus       (aGatesN[3]),
        .minus      (aGatesN[2]),
        .plusPrime  (aGatesN[1]),
        .minusPrime (aGatesN[0])
    );

    fw_coil_driver uCoilB (
        .code       (bCodeN),
        .plus       (bGatesN[3]),
        .minus      (bGatesN[2]),
        .plusPrime  (bGatesN[1]),
        .minusPrime (bGatesN[0])
    );

    always_ff @(posedge clk or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            state      <= S_IDLE;
            phase      <= 2'd0;
            dir        <= 1'b0;
            prime      <= 1'b0;
            period     <= '0;
            cnt        <= '0;
            steps_left <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            home_hit   <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            {MotorDriveAPlus, MotorDriveAMinus, MotorDriveAPlusPrime, MotorDriveAMinusPrime} <= 4'b0000;
            {MotorDriveBPlus, MotorDriveBMinus, MotorDriveBPlusPrime, MotorDriveBMinusPrime} <= 4'b0000;
        end else begin
            state      <= stateN;
            phase      <= phaseN;
            dir        <= dirN;
            prime      <= primeN;
            period     <= periodN;
            cnt        <= cntN;
            steps_left <= stepsN;
            done       <= doneN;
            aborted    <= abortedN;
            home_hit   <= homeHitN;
            busy       <= (stateN != S_IDLE);
            cmd_ready  <= (stateN == S_IDLE);
            {MotorDriveAPlus, MotorDriveAMinus, MotorDriveAPlusPrime, MotorDriveAMinusPrime} <= aGatesN;
            {MotorDriveBPlus, MotorDriveBMinus, MotorDriveBPlusPrime, MotorDriveBMinusPrime} <= bGatesN;
        end
    end

endmodule

// File: tb/tb_fw_stepper_sequencer.sv
// Directed self-checking bench for fw_stepper_sequencer (default parameters).
module tb_fw_stepper_sequencer;

    logic        clk = 1'b0;
    logic        DEVRST_N;
    logic        cmd_valid, cmd_dir, hold_en, abort, home_raw;
    logic [15:0] cmd_steps, step_period;
    logic        cmd_ready, busy, done, aborted, home_hit;
    logic [15:0] steps_left;
    logic [1:0]  phase, dbgState;
    logic        aP, aM, bP, bM, aPp, aMp, bPp, bMp;
    logic [7:0]  gates;

    int checks = 0;
    int fails  = 0;
    int overlapCnt = 0;

    // Per-coil nibble {Plus, Minus, PlusPrime, MinusPrime}: fwd = 9, rev = 6, off = 0.
    assign gates = {aP, aM, aPp, aMp, bP, bM, bPp, bMp};

    fw_stepper_sequencer dut (
        .clk(clk), .DEVRST_N(DEVRST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .step_period(step_period), .hold_en(hold_en),
        .abort(abort), .home_raw(home_raw), .busy(busy), .done(done),
        .aborted(aborted), .home_hit(home_hit), .steps_left(steps_left), .phase(phase),
        .MotorDriveAPlus(aP), .MotorDriveAMinus(aM), .MotorDriveBPlus(bP), .MotorDriveBMinus(bM),
        .MotorDriveAPlusPrime(aPp), .MotorDriveAMinusPrime(aMp),
        .MotorDriveBPlusPrime(bPp), .MotorDriveBMinusPrime(bMp),
        .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((aP & aPp) | (aM & aMp) | (bP & bPp) | (bM & bMp)) overlapCnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic d, input logic [15:0] s, input logic [15:0] p);
        cmd_dir     = d;
        cmd_steps   = s;
        step_period = p;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic test_reset();
        DEVRST_N = 1'b0;
        tick(); tick();
        checks++; if ({busy, done, aborted, home_hit, cmd_ready} !== 5'b00001) begin fails++;
            $display("FAIL reset_flags: got %b want 00001", {busy, done, aborted, home_hit, cmd_ready}); end
        checks++; if (gates !== 8'h00) begin fails++; $display("FAIL reset_gates: got %h want 00", gates); end
        checks++; if (phase !== 2'd0 || steps_left !== 16'd0) begin fails++;
            $display("FAIL reset_state: phase %0d steps %0d want 0 0", phase, steps_left); end
        DEVRST_N = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1 || gates !== 8'h00) begin fails++;
            $display("FAIL reset_release: ready %b gates %h want 1 00", cmd_ready, gates); end
    endtask

    task automatic test_fwd_move();
        int doneEdge;
        doneEdge = -1;
        hold_en = 1'b1;
        tick(); tick();
        checks++; if (gates !== 8'h99) begin fails++; $display("FAIL fwd_hold: got %h want 99", gates); end
        send_cmd(1'b1, 16'd4, 16'd100);
        checks++; if ({busy, cmd_ready, done} !== 3'b100) begin fails++;
            $display("FAIL fwd_accept: busy/ready/done %b want 100", {busy, cmd_ready, done}); end
        checks++; if (gates !== 8'h09) begin fails++; $display("FAIL fwd_dead_start: got %h want 09", gates); end
        checks++; if (dbgState !== 2'd1) begin fails++; $display("FAIL fwd_state: got %0d want 1", dbgState); end
        for (int e = 1; e <= 600; e++) begin
            tick();
            if (e == 7) begin
                checks++; if (gates !== 8'h09) begin fails++; $display("FAIL fwd_dead_end: got %h want 09", gates); end
            end
            if (e == 8) begin
                checks++; if (phase !== 2'd1 || gates !== 8'h69) begin fails++;
                    $display("FAIL fwd_step1: phase %0d gates %h want 1 69", phase, gates); end
            end
            if (e == 108) begin
                checks++; if (steps_left !== 16'd3 || gates !== 8'h60) begin fails++;
                    $display("FAIL fwd_step2_dead: steps %0d gates %h want 3 60", steps_left, gates); end
            end
            if (done) begin doneEdge = e; break; end
        end
        checks++; if (doneEdge !== 432) begin fails++; $display("FAIL fwd_done_time: got %0d want 432", doneEdge); end
        checks++; if (phase !== 2'd0 || steps_left !== 16'd0 || busy !== 1'b0) begin fails++;
            $display("FAIL fwd_end: phase %0d steps %0d busy %b want 0 0 0", phase, steps_left, busy); end
        checks++; if (gates !== 8'h99) begin fails++; $display("FAIL fwd_end_gates: got %h want 99", gates); end
        tick();
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL fwd_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_rev_move();
        int doneEdge;
        doneEdge = -1;
        send_cmd(1'b0, 16'd1, 16'd64);
        checks++; if (gates !== 8'h90) begin fails++; $display("FAIL rev_dead_start: got %h want 90", gates); end
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (e == 7) begin
                checks++; if (gates !== 8'h90) begin fails++; $display("FAIL rev_dead_end: got %h want 90", gates); end
            end
            if (e == 8) begin
                checks++; if (phase !== 2'd3 || gates !== 8'h96) begin fails++;
                    $display("FAIL rev_step: phase %0d gates %h want 3 96", phase, gates); end
            end
            if (done) begin doneEdge = e; break; end
        end
        checks++; if (doneEdge !== 72) begin fails++; $display("FAIL rev_done_time: got %0d want 72", doneEdge); end
    endtask

    task automatic test_min_period();
        int doneEdge;
        doneEdge = -1;
        send_cmd(1'b1, 16'd2, 16'd5);
        step_period = 16'd1000;
        checks++; if (gates !== 8'h90) begin fails++; $display("FAIL minp_dead_start: got %h want 90", gates); end
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (done) begin doneEdge = e; break; end
        end
        checks++; if (doneEdge !== 144) begin fails++; $display("FAIL minp_done_time: got %0d want 144", doneEdge); end
        checks++; if (phase !== 2'd1) begin fails++; $display("FAIL minp_phase: got %0d want 1", phase); end
    endtask

    task automatic test_zero_steps();
        hold_en = 1'b0;
        tick();
        checks++; if (gates !== 8'h00) begin fails++; $display("FAIL idle_unheld_gates: got %h want 00", gates); end
        send_cmd(1'b1, 16'd0, 16'd100);
        checks++; if ({done, busy, cmd_ready} !== 3'b101) begin fails++;
            $display("FAIL zero_accept: done/busy/ready %b want 101", {done, busy, cmd_ready}); end
        checks++; if (phase !== 2'd1 || steps_left !== 16'd0 || gates !== 8'h00) begin fails++;
            $display("FAIL zero_outputs: phase %0d steps %0d gates %h want 1 0 00", phase, steps_left, gates); end
        tick();
        checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL zero_after: done/busy %b want 00", {done, busy}); end
    endtask

    task automatic test_unheld_start();
        int doneEdge;
        doneEdge = -1;
        send_cmd(1'b1, 16'd1, 16'd64);
        checks++; if (gates !== 8'h69) begin fails++; $display("FAIL unheld_prime: got %h want 69", gates); end
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (e == 8) begin
                checks++; if (gates !== 8'h60) begin fails++; $display("FAIL unheld_dead: got %h want 60", gates); end
            end
            if (e == 16) begin
                checks++; if (phase !== 2'd2 || gates !== 8'h66) begin fails++;
                    $display("FAIL unheld_step: phase %0d gates %h want 2 66", phase, gates); end
            end
            if (done) begin doneEdge = e; break; end
        end
        checks++; if (doneEdge !== 80 || gates !== 8'h00) begin fails++;
            $display("FAIL unheld_done: edge %0d gates %h want 80 00", doneEdge, gates); end
    endtask

    task automatic test_reset_mid_move();
        int doneSeen;
        doneSeen = 0;
        hold_en = 1'b1;
        send_cmd(1'b1, 16'd5, 16'd64);
        repeat (20) tick();
        DEVRST_N = 1'b0;
        #1;
        checks++; if (gates !== 8'h00) begin fails++; $display("FAIL rstmid_gates: got %h want 00", gates); end
        checks++; if ({busy, done, cmd_ready} !== 3'b001 || phase !== 2'd0) begin fails++;
            $display("FAIL rstmid_state: busy/done/ready %b phase %0d want 001 0", {busy, done, cmd_ready}, phase); end
        repeat (3) begin tick(); if (done) doneSeen++; end
        DEVRST_N = 1'b1;
        repeat (3) begin tick(); if (done) doneSeen++; end
        checks++; if (doneSeen !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d want 0", doneSeen); end
        checks++; if (gates !== 8'h99) begin fails++; $display("FAIL rstmid_hold: got %h want 99", gates); end
    endtask

    task automatic test_abort();
        send_cmd(1'b1, 16'd10, 16'd64);
        repeat (74) tick();
        abort = 1'b1;
        tick();
        checks++; if ({done, aborted, busy, cmd_ready} !== 4'b1101) begin fails++;
            $display("FAIL abort_flags: done/aborted/busy/ready %b want 1101", {done, aborted, busy, cmd_ready}); end
        checks++; if (phase !== 2'd1 || steps_left !== 16'd9) begin fails++;
            $display("FAIL abort_hold: phase %0d steps %0d want 1 9", phase, steps_left); end
        checks++; if (gates !== 8'h69) begin fails++; $display("FAIL abort_gates: got %h want 69", gates); end
        abort = 1'b0;
        tick();
        checks++; if ({done, aborted} !== 2'b01) begin fails++; $display("FAIL abort_after: done/aborted %b want 01", {done, aborted}); end
        checks++; if (overlapCnt !== 0) begin fails++; $display("FAIL overlap_abort: got %0d want 0", overlapCnt); end
    endtask

    task automatic test_abort_with_cmd();
        abort = 1'b1;
        tick();
        checks++; if ({done, cmd_ready} !== 2'b01) begin fails++;
            $display("FAIL abort_idle: done/ready %b want 01", {done, cmd_ready}); end
        send_cmd(1'b1, 16'd3, 16'd64);
        checks++; if ({busy, aborted, done} !== 3'b100) begin fails++;
            $display("FAIL abortcmd_accept: busy/aborted/done %b want 100", {busy, aborted, done}); end
        tick();
        checks++; if ({done, aborted, busy} !== 3'b110 || phase !== 2'd1 || steps_left !== 16'd3) begin fails++;
            $display("FAIL abortcmd_stop: flags %b phase %0d steps %0d want 110 1 3", {done, aborted, busy}, phase, steps_left); end
        abort = 1'b0;
        tick();
    endtask

    task automatic test_home();
        int doneEdge;
        doneEdge = -1;
        send_cmd(1'b1, 16'd20, 16'd64);
        for (int e = 1; e <= 1600; e++) begin
            tick();
            if (e == 300) home_raw = 1'b1;
            if (done) begin doneEdge = e; break; end
        end
        home_raw = 1'b0;
`ifdef FW_HOME_STOP_EN
        checks++; if (!(doneEdge >= 301 && doneEdge <= 303)) begin fails++;
            $display("FAIL home_time: got %0d want 301..303", doneEdge); end
        checks++; if ({home_hit, aborted} !== 2'b10) begin fails++;
            $display("FAIL home_flags: home_hit/aborted %b want 10", {home_hit, aborted}); end
        checks++; if (!(steps_left == 16'd15 || steps_left == 16'd16) || phase !== 2'd2) begin fails++;
            $display("FAIL home_hold: steps %0d phase %0d want 15/16 2", steps_left, phase); end
`else
        checks++; if (doneEdge !== 1440) begin fails++; $display("FAIL home_ignored_time: got %0d want 1440", doneEdge); end
        checks++; if ({home_hit, aborted} !== 2'b00 || steps_left !== 16'd0 || phase !== 2'd1) begin fails++;
            $display("FAIL home_ignored_end: flags %b steps %0d phase %0d want 00 0 1", {home_hit, aborted}, steps_left, phase); end
`endif
        checks++; if (overlapCnt !== 0) begin fails++; $display("FAIL overlap_total: got %0d want 0", overlapCnt); end
    endtask

    initial begin
        DEVRST_N    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 1'b0;
        cmd_steps   = 16'd0;
        step_period = 16'd0;
        hold_en     = 1'b0;
        abort       = 1'b0;
        home_raw    = 1'b0;
        test_reset();
        test_fwd_move();
        test_rev_move();
        test_min_period();
        test_zero_steps();
        test_unheld_start();
        test_reset_mid_move();
        test_abort();
        test_abort_with_cmd();
        test_home();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
